mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Round-robin controller that shares one sequential 8x8 multiplier core (start/a/b in, d_out/done out) between NREQ requesters. It arbitrates, latches the winner's operands, pulses the core's start, waits for done (with timeout), and returns the 16-bit product to the winning requester. It sits between the requesting datapath blocks and the multiplier core at the same level as the core's top.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, operand width; product width is 2*W
- TMO, 64, maximum BUSY cycles before error completion (>= core latency + 2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- a_in  in  NREQ*W  flattened operand A; requester i uses bits [i*W +: W]
- b_in  in  NREQ*W  flattened operand B, same packing
- ack  out  NREQ  one-hot, one-cycle completion pulse to the served requester
- rsp_data  out  2*W  product; valid only while ack != 0
- rsp_err  out  1  timeout flag; valid only while ack != 0
- m_start  out  1  one-cycle start pulse to the multiplier core
- m_a  out  W  operand A to core, stable from ISSUE until leaving BUSY
- m_b  out  W  operand B to core, same rule
- m_done  in  1  core completion (pulse or level)
- m_d  in  2*W  core product, valid while m_done=1

## Operation
- States: IDLE, ISSUE, BUSY, RESP, WAIT_CLR.
- IDLE: if any req bit set, pick the first set bit scanning upward from (last+1) mod NREQ, wrapping; register m_a/m_b from that slot, store grant index, update last, go ISSUE. No req -> stay.
- ISSUE: m_start=1 for exactly this cycle; clear timeout counter; go BUSY.
- BUSY: counter increments each cycle. On m_done=1, capture m_d into result register, err=0, go RESP. If counter reaches TMO-1 with m_done=0, result=0, err=1, go RESP. m_done takes priority when both occur in the same cycle.
- RESP: ack[grant]=1, rsp_data=result, rsp_err=err for this cycle only; go WAIT_CLR.
- WAIT_CLR: stay while m_done=1 (level-style cores); go IDLE when m_done=0.
- req is sampled only in IDLE; changes to req/a_in/b_in in other states are ignored. Operands are latched at grant, so a requester may change operands after grant.
- Requester protocol: hold req (and operands) until ack is seen, then drop req. The FSM path guarantees at least one IDLE-free cycle after ack, so a dropped req is never re-granted.
- m_done outside BUSY/WAIT_CLR is ignored.
- Reset (any time, including mid-transaction): state=IDLE, last=NREQ-1 (requester 0 wins first), ack=0, rsp_data=0, rsp_err=0, m_start=0, m_a=0, m_b=0, counter=0. Nothing in flight is reported after reset.

## Timing
- Req seen in IDLE at cycle t: m_start=1 at t+1; BUSY from t+2.
- m_done first high at cycle k (in BUSY): ack pulse at k+1; IDLE at k+3 if m_done low at k+2.
- Service time per request = core latency + 4 cycles minimum; worst-case wait for any continuously requesting client is NREQ-1 service times.
- Timeout: with no m_done, ack with rsp_err=1 occurs TMO cycles after BUSY entry.
- All outputs are registered; no combinational path from req, a_in, b_in, or m_done to any output.

## Test plan
- Single request: req=4'b0001, a=8'h81, b=8'h13 -> one m_start pulse with m_a=8'h81, m_b=8'h13; ack=4'b0001 with rsp_data=16'h0993, rsp_err=0.
- All request together: req=4'b1111, holding each until acked -> grants in order 0,1,2,3, each with its own product (e.g. slot 2 a=8'hF0, b=8'h35 -> 16'h31B0); exactly one ack per transaction.
- Round-robin wrap: after serving 2, req=4'b0101 -> 0 served before 2; then req=4'b1001 with last=0 -> 3 served before 0.
- Level done: core holds m_done high for 5 cycles -> single ack; no new m_start until m_done falls.
- Timeout: stub core never asserts m_done, TMO=16 -> ack with rsp_err=1, rsp_data=0, 16 cycles after BUSY entry; next request proceeds normally.
- Reset mid-BUSY: assert rst=0 for 1 cycle -> all outputs 0 immediately; no ack for the aborted request; a new req=4'b0010 is served normally.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier core between NREQ requesters.
// Latches the winner's operands, starts the core, waits for done or timeout, returns the product.
module mul_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int TMO  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   ack,
  output logic [2*W-1:0]    rsp_data,
  output logic              rsp_err,
  output logic              m_start,
  output logic [W-1:0]      m_a,
  output logic [W-1:0]      m_b,
  input  logic              m_done,
  input  logic [2*W-1:0]    m_d
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, WAIT_CLR} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    m_a_q, m_a_d;
  logic [W-1:0]    m_b_q, m_b_d;
  logic            m_start_q, m_start_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [2*W-1:0]  rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];
  logic            found;
  logic [IW-1:0]   sel;
  int              idx;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = a_in[i*W +: W];
      b_arr[i] = b_in[i*W +: W];
    end
  end

  // Scan upward from last+1, wrapping, and keep the first requester found.
  always_comb begin
    found = 1'b0;
    sel   = last_q;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    m_a_d      = m_a_q;
    m_b_d      = m_b_q;
    m_start_d  = 1'b0;
    ack_d      = '0;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d   = sel;
          last_d    = sel;
          m_a_d     = a_arr[sel];
          m_b_d     = b_arr[sel];
          m_start_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      // A done seen on the last allowed cycle still wins over the timeout.
      BUSY: begin
        if (m_done) begin
          rsp_data_d = m_d;
          ack_d      = NREQ'(1) << grant_q;
          state_d    = RESP;
        end else if (cnt_q == CW'(TMO - 1)) begin
          rsp_err_d = 1'b1;
          ack_d     = NREQ'(1) << grant_q;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: state_d = WAIT_CLR;
      WAIT_CLR: begin
        if (!m_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= IW'(NREQ - 1);
      grant_q    <= '0;
      cnt_q      <= '0;
      m_a_q      <= '0;
      m_b_q      <= '0;
      m_start_q  <= 1'b0;
      ack_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      m_a_q      <= m_a_d;
      m_b_q      <= m_b_d;
      m_start_q  <= m_start_d;
      ack_q      <= ack_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign ack      = ack_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign m_start  = m_start_q;
  assign m_a      = m_a_q;
  assign m_b      = m_b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized bench for mul_arbiter: a stub multiplier core plus a round-robin/product
// reference model; each scenario task checks its own results.
module tb_mul_arbiter;

  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*W-1:0]   a_in, b_in;
  logic [NR-1:0]     ack;
  logic [2*W-1:0]    rsp_data;
  logic              rsp_err;
  logic              m_start;
  logic [W-1:0]      m_a, m_b;
  logic              m_done;
  logic [2*W-1:0]    m_d;

  logic [W-1:0]      op_a [NR];
  logic [W-1:0]      op_b [NR];

  logic              core_done = 1'b0;
  logic [2*W-1:0]    core_d = '0;
  logic [2*W-1:0]    core_prod = '0;
  logic              spur_done = 1'b0;
  logic [2*W-1:0]    spur_d = '0;
  int                core_lat = 3;
  int                core_hold = 1;
  bit                core_never = 1'b0;
  int                cd = 0;
  int                hold = 0;

  int                n_cmp = 0;
  int                n_fail = 0;
  int                ack_count = 0;
  int                start_count = 0;
  int                model_last = NR - 1;

  assign a_in   = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign b_in   = {op_b[3], op_b[2], op_b[1], op_b[0]};
  assign m_done = core_done | spur_done;
  assign m_d    = spur_done ? spur_d : core_d;

  mul_arbiter #(.NREQ(NR), .W(W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_start(m_start), .m_a(m_a), .m_b(m_b), .m_done(m_done), .m_d(m_d)
  );

  always #5 clk = ~clk;

  // Stub core: done rises core_lat cycles after the start cycle and stays high core_hold cycles.
  always @(negedge clk) begin
    if (!rst) begin
      cd = 0;
      hold = 0;
      core_done = 1'b0;
    end else begin
      if (core_done) begin
        if (hold > 0) hold--;
        else begin
          core_done = 1'b0;
          core_d = 16'($urandom);
        end
      end
      if (m_start === 1'b1) begin
        core_prod = {8'h0, m_a} * {8'h0, m_b};
        cd = core_never ? 0 : core_lat;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          core_done = 1'b1;
          core_d = core_prod;
          hold = core_hold - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst === 1'b1) begin
      if (ack !== '0) ack_count++;
      if (m_start === 1'b1) start_count++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  function automatic int model_winner(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return 0;
  endfunction

  task automatic wait_start(input int budget, output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (m_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (ack !== '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < NR; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (ack !== '0) begin n_fail++; $display("[TB] FAIL reset_ack: got %b expected 0", ack); end
    n_cmp++; if (rsp_data !== '0) begin n_fail++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    n_cmp++; if (m_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_start: got %b expected 0", m_start); end
    n_cmp++; if (m_a !== '0 || m_b !== '0) begin n_fail++; $display("[TB] FAIL reset_operands: got %h/%h expected 0/0", m_a, m_b); end
    rst = 1'b1;
    model_last = NR - 1;
    repeat (3) @(negedge clk);
    n_cmp++; if (m_start !== 1'b0 || ack !== '0) begin n_fail++; $display("[TB] FAIL idle_quiet: got start=%b ack=%b expected 0/0", m_start, ack); end
  endtask

  task automatic test_round_robin(input logic [NR-1:0] pattern);
    logic [NR-1:0] pending;
    logic [W-1:0]  ea, eb;
    logic [2*W-1:0] ep;
    int w, n, acks0, starts0, nbits;
    bit ok;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      op_a[i] = 8'($urandom);
      op_b[i] = 8'($urandom);
    end
    if (pattern == 4'b1111) begin
      op_a[2] = 8'hF0;
      op_b[2] = 8'h35;
    end
    acks0 = ack_count;
    starts0 = start_count;
    nbits = $countones(pattern);
    pending = pattern;
    req = pending;
    while (pending != '0) begin
      w = model_winner(pending, model_last);
      ea = op_a[w];
      eb = op_b[w];
      ep = {8'h0, ea} * {8'h0, eb};
      core_lat = $urandom_range(1, 8);
      wait_start(TMO + 20, ok, n);
      n_cmp++;
      if (!ok) begin n_fail++; $display("[TB] FAIL rr_start: got no m_start expected start for slot %0d", w); req = '0; return; end
      n_cmp++; if (m_a !== ea) begin n_fail++; $display("[TB] FAIL rr_m_a slot %0d: got %h expected %h", w, m_a, ea); end
      n_cmp++; if (m_b !== eb) begin n_fail++; $display("[TB] FAIL rr_m_b slot %0d: got %h expected %h", w, m_b, eb); end
      op_a[w] = ~op_a[w];
      op_b[w] = op_b[w] + 8'd1;
      wait_ack(TMO + 20, ok, n);
      n_cmp++;
      if (!ok) begin n_fail++; $display("[TB] FAIL rr_ack_wait: got no ack expected ack for slot %0d", w); req = '0; return; end
      n_cmp++; if (ack !== 4'(1 << w)) begin n_fail++; $display("[TB] FAIL rr_ack: got %b expected %b", ack, 4'(1 << w)); end
      n_cmp++; if (rsp_data !== ep) begin n_fail++; $display("[TB] FAIL rr_data slot %0d: got %h expected %h", w, rsp_data, ep); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_err: got %b expected 0", rsp_err); end
      pending[w] = 1'b0;
      req = pending;
      model_last = w;
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (ack_count - acks0 != nbits) begin n_fail++; $display("[TB] FAIL rr_ack_count: got %0d expected %0d", ack_count - acks0, nbits); end
    n_cmp++; if (start_count - starts0 != nbits) begin n_fail++; $display("[TB] FAIL rr_start_count: got %0d expected %0d", start_count - starts0, nbits); end
  endtask

  task automatic test_single();
    int n;
    bit ok;
    repeat (2) @(negedge clk);
    op_a[0] = 8'h81;
    op_b[0] = 8'h13;
    core_lat = 3;
    req = 4'b0001;
    wait_start(20, ok, n);
    n_cmp++; if (!ok || n != 1) begin n_fail++; $display("[TB] FAIL single_start_latency: got ok=%b n=%0d expected 1", ok, n); end
    n_cmp++; if (m_a !== 8'h81 || m_b !== 8'h13) begin n_fail++; $display("[TB] FAIL single_operands: got %h/%h expected 81/13", m_a, m_b); end
    @(negedge clk);
    n_cmp++; if (m_start !== 1'b0) begin n_fail++; $display("[TB] FAIL single_start_pulse: got %b expected 0", m_start); end
    wait_ack(TMO + 20, ok, n);
    n_cmp++; if (!ok || n != 3) begin n_fail++; $display("[TB] FAIL single_ack_latency: got ok=%b n=%0d expected 3", ok, n); end
    n_cmp++; if (ack !== 4'b0001 || rsp_data !== 16'h0993 || rsp_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL single_rsp: got ack=%b data=%h err=%b expected 0001/0993/0", ack, rsp_data, rsp_err);
    end
    req = '0;
    model_last = 0;
    @(negedge clk);
    n_cmp++; if (ack !== '0) begin n_fail++; $display("[TB] FAIL single_ack_pulse: got %b expected 0", ack); end
  endtask

  task automatic test_level_done();
    logic [NR-1:0] pending;
    int w1, w2, n, acks0;
    bit ok;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      op_a[i] = 8'($urandom);
      op_b[i] = 8'($urandom);
    end
    acks0 = ack_count;
    pending = 4'b0110;
    w1 = model_winner(pending, model_last);
    core_lat = 2;
    core_hold = 5;
    req = pending;
    wait_start(20, ok, n);
    wait_ack(TMO + 20, ok, n);
    n_cmp++; if (!ok || ack !== 4'(1 << w1) || rsp_data !== {8'h0, op_a[w1]} * {8'h0, op_b[w1]}) begin
      n_fail++; $display("[TB] FAIL level_first: got ok=%b ack=%b data=%h expected slot %0d", ok, ack, rsp_data, w1);
    end
    pending[w1] = 1'b0;
    req = pending;
    model_last = w1;
    core_hold = 1;
    w2 = model_winner(pending, model_last);
    wait_start(20, ok, n);
    n_cmp++; if (!ok || n != 6) begin n_fail++; $display("[TB] FAIL level_restart_delay: got ok=%b n=%0d expected 6", ok, n); end
    n_cmp++; if (m_a !== op_a[w2]) begin n_fail++; $display("[TB] FAIL level_second_m_a: got %h expected %h", m_a, op_a[w2]); end
    wait_ack(TMO + 20, ok, n);
    n_cmp++; if (!ok || ack !== 4'(1 << w2)) begin n_fail++; $display("[TB] FAIL level_second_ack: got %b expected %b", ack, 4'(1 << w2)); end
    req = '0;
    model_last = w2;
    repeat (2) @(negedge clk);
    n_cmp++; if (ack_count - acks0 != 2) begin n_fail++; $display("[TB] FAIL level_ack_count: got %0d expected 2", ack_count - acks0); end
  endtask

  task automatic test_spurious_done();
    int bad;
    bad = 0;
    @(negedge clk);
    req = '0;
    spur_d = 16'($urandom);
    spur_done = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ack !== '0 || m_start !== 1'b0 || rsp_data !== '0) bad++;
    end
    spur_done = 1'b0;
    n_cmp++; if (bad != 0) begin n_fail++; $display("[TB] FAIL spurious_done: got %0d active cycles expected 0", bad); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    repeat (2) @(negedge clk);
    op_a[3] = 8'($urandom_range(1, 255));
    op_b[3] = 8'($urandom_range(1, 255));
    core_never = 1'b1;
    req = 4'b1000;
    wait_start(20, ok, n);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL timeout_start: got no m_start expected one"); end
    wait_ack(TMO + 20, ok, n);
    n_cmp++; if (!ok || n != TMO + 1) begin n_fail++; $display("[TB] FAIL timeout_latency: got ok=%b n=%0d expected %0d", ok, n, TMO + 1); end
    n_cmp++; if (ack !== 4'b1000 || rsp_data !== '0 || rsp_err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL timeout_rsp: got ack=%b data=%h err=%b expected 1000/0000/1", ack, rsp_data, rsp_err);
    end
    req = '0;
    model_last = 3;
    core_never = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int n, acks0;
    bit ok;
    repeat (2) @(negedge clk);
    op_a[1] = 8'($urandom_range(1, 255));
    op_b[1] = 8'($urandom_range(1, 255));
    core_lat = 10;
    req = 4'b0010;
    wait_start(20, ok, n);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL midrst_start: got no m_start expected one"); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (ack !== '0 || m_start !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0 || m_a !== '0 || m_b !== '0) begin
      n_fail++; $display("[TB] FAIL midrst_outputs: got ack=%b st=%b d=%h e=%b a=%h b=%h expected all 0", ack, m_start, rsp_data, rsp_err, m_a, m_b);
    end
    acks0 = ack_count;
    req = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    model_last = NR - 1;
    repeat (15) @(negedge clk);
    n_cmp++; if (ack_count != acks0) begin n_fail++; $display("[TB] FAIL midrst_no_ack: got %0d acks expected 0", ack_count - acks0); end
  endtask

  initial begin
    test_reset();
    test_round_robin(4'b1111);
    test_single();
    test_round_robin(4'b0100);
    test_round_robin(4'b0101);
    test_round_robin(4'b0001);
    test_round_robin(4'b1001);
    test_level_done();
    test_spurious_done();
    test_timeout();
    test_round_robin(4'b0110);
    test_reset_mid_busy();
    test_round_robin(4'b0010);
    for (int r = 0; r < 8; r++) test_round_robin(4'($urandom_range(1, 15)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
